// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcode encodings and FSM states.
package calc_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_MOD  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_ISSUE = 2'd2,
    S_CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/calc_prog_mem.sv
// Program store: PROG_DEPTH entries of {op, data}, one write port, one async read port.
module calc_prog_mem #(
  parameter int WIDTH      = 8,
  parameter int PROG_DEPTH = 16,
  localparam int IW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [2:0]       wop,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [2:0]       rop,
  output logic [WIDTH-1:0] rdata
);

  logic [2:0]       op_q   [PROG_DEPTH];
  logic [WIDTH-1:0] data_q [PROG_DEPTH];

  // Contents are not reset; prog_len in the sequencer decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      op_q[waddr]   <= wop;
      data_q[waddr] <= wdata;
    end
  end

  assign rop   = op_q[raddr];
  assign rdata = data_q[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// Replays a stored instruction program into the queue calculator, one op per
// two cycles, and reports done/result or the index of the first failing op.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PROG_DEPTH = 16,
  localparam int IW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IW-1:0]    error_idx,
  output logic [WIDTH-1:0] result,
  output logic             prog_full,
  output logic [WIDTH-1:0] calc_in,
  output logic [2:0]       calc_op,
  output logic             calc_apply,
  output logic             calc_reset,
  input  logic [WIDTH-1:0] calc_tail,
  input  logic             calc_valid,
  input  logic             calc_empty
);

  localparam logic [IW:0] DEPTH_L = (IW+1)'(PROG_DEPTH);

  state_t           state, state_d;
  logic [IW:0]      prog_len;
  logic [IW-1:0]    idx;
  logic [2:0]       rd_op;
  logic [WIDTH-1:0] rd_data;
  logic             wr_ok, last;

  assign wr_ok     = (state == S_IDLE) && wr_en && !clear && (prog_len < DEPTH_L);
  assign last      = ({1'b0, idx} == (prog_len - 1'b1));
  assign prog_full = (prog_len == DEPTH_L);
  assign busy      = (state != S_IDLE);
  // Combinational so the calculator is held in reset alongside the sequencer.
  assign calc_reset = reset | (state == S_CLR);

  calc_prog_mem #(.WIDTH(WIDTH), .PROG_DEPTH(PROG_DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (prog_len[IW-1:0]),
    .wop   (wr_op),
    .wdata (wr_data),
    .raddr (idx),
    .rop   (rd_op),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    calc_apply = 1'b0;
    calc_op    = '0;
    calc_in    = '0;
    case (state)
      S_IDLE:  if (start && prog_len != '0) state_d = S_CLR;
      S_CLR:   state_d = S_ISSUE;
      S_ISSUE: begin
        calc_apply = 1'b1;
        calc_op    = rd_op;
        calc_in    = rd_data;
        state_d    = S_CHECK;
      end
      S_CHECK: state_d = (!calc_valid || last) ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_len  <= '0;
      idx       <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      error_idx <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear)      prog_len <= '0;
          else if (wr_ok) prog_len <= prog_len + 1'b1;
          if (start) begin
            done      <= 1'b0;
            error     <= (prog_len == '0);
            error_idx <= '0;
            result    <= '0;
            idx       <= '0;
          end
        end
        S_CHECK: begin
          if (!calc_valid) begin
            error     <= 1'b1;
            error_idx <= idx;
          end else if (last) begin
            if (calc_empty) begin
              error     <= 1'b1;
              error_idx <= idx;
            end else begin
              done   <= 1'b1;
              result <= calc_tail;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
